fetch_prefetch_buffer: RTL



---
 rtl/fetch_prefetch_buffer_pkg.sv | 27 ++
 rtl/fetch_ilen_decode.sv | 24 ++
 rtl/fetch_prefetch_buffer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_buffer_pkg.sv
// rtl/fetch_prefetch_buffer_pkg.sv - Y86-64 icodes, instruction lengths and status codes
package fetch_prefetch_buffer_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] LEN_1  = 4'd1;
   localparam logic [3:0] LEN_2  = 4'd2;
   localparam logic [3:0] LEN_9  = 4'd9;
   localparam logic [3:0] LEN_10 = 4'd10;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

endpackage

// File: rtl/fetch_ilen_decode.sv
// rtl/fetch_ilen_decode.sv - icode to instruction length and invalid flag
module fetch_ilen_decode
   import fetch_prefetch_buffer_pkg::*;
(
   input  logic [3:0] i_icode,
   output logic [3:0] o_len,
   output logic       o_invalid
);

   always_comb begin
      o_invalid = 1'b0;
      case (i_icode)
         I_HALT, I_NOP, I_RET:               o_len = LEN_1;
         I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:   o_len = LEN_2;
         I_JXX, I_CALL:                      o_len = LEN_9;
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:       o_len = LEN_10;
         default: begin
            o_len     = LEN_1;
            o_invalid = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// rtl/fetch_prefetch_buffer.sv - instruction prefetch byte queue feeding the fetch stage
module fetch_prefetch_buffer
   import fetch_prefetch_buffer_pkg::*;
#(
   parameter logic [63:0] RESET_PC        = 64'h0,
   parameter int          BUF_WORDS       = 3,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_redirect_valid,
   input  logic [63:0] i_redirect_pc,
   output logic        o_inst_valid,
   output logic [79:0] o_inst_bytes,
   output logic [63:0] o_inst_pc,
   output logic [3:0]  o_inst_len,
   output logic        o_inst_invalid,
   output logic        o_inst_err,
   input  logic        i_inst_take,
   output logic        o_imem_req_valid,
   input  logic        i_imem_req_ready,
   output logic [63:0] o_imem_req_addr,
   input  logic        i_imem_rsp_valid,
   input  logic [63:0] i_imem_rsp_data,
   input  logic        i_imem_rsp_err
);

   localparam int         QB   = 8 * BUF_WORDS;
   localparam logic [6:0] QB7  = 7'(QB);
   localparam logic [2:0] MAXO = 3'(MAX_OUTSTANDING);

   // Head of the queue is always index 0; slots at or beyond r_count are kept zero.
   logic [7:0]  r_qd [QB];
   logic        r_qe [QB];
   logic [5:0]  r_count;
   logic [2:0]  r_out;
   logic [2:0]  r_discard;
   logic [2:0]  r_skip;
   logic [63:0] r_fetch_addr;
   logic [63:0] r_head_pc;
   logic        r_halted;

   logic [7:0]  w_qd [QB];
   logic        w_qe [QB];
   logic [5:0]  w_count;
   logic [2:0]  w_out;
   logic [2:0]  w_discard;
   logic [2:0]  w_skip;
   logic [63:0] w_fetch_addr;
   logic [63:0] w_head_pc;
   logic        w_halted;
   logic [3:0]  w_len;
   logic        w_invalid;
   logic        w_take;
   logic        w_acc;
   logic        w_keep;
   logic [5:0]  w_pop;
   logic [5:0]  w_base;
   logic [6:0]  w_need;

   fetch_ilen_decode u_ilen_decode (
      .i_icode   (r_qd[0][7:4]),
      .o_len     (w_len),
      .o_invalid (w_invalid)
   );

   always_comb begin
      o_inst_len     = w_len;
      o_inst_invalid = w_invalid;
      o_inst_pc      = r_head_pc;
      o_inst_valid   = ({2'b00, w_len} <= r_count) || (r_qe[0] && (r_count != 6'd0));
      o_inst_bytes   = '0;
      o_inst_err     = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i < int'(w_len)) begin
            o_inst_bytes[8*i +: 8] = r_qd[i];
            o_inst_err             = o_inst_err | r_qe[i];
         end
      end
      // Space is reserved for every in-flight word so a response can always be appended.
      w_need           = {1'b0, r_count} + {1'b0, r_out + 3'd1, 3'b000};
      o_imem_req_valid = rst_n && !r_halted && (r_out < MAXO) && (w_need <= QB7);
      o_imem_req_addr  = r_fetch_addr;
   end

   always_comb begin
      w_acc  = o_imem_req_valid && i_imem_req_ready;
      w_keep = i_imem_rsp_valid && (r_discard == 3'd0);
      w_take = i_inst_take && o_inst_valid && !i_redirect_valid;
      w_pop  = '0;
      if (w_take) begin
         w_pop = ({2'b00, w_len} > r_count) ? r_count : {2'b00, w_len};
      end
      w_out  = r_out + {2'b00, w_acc} - {2'b00, i_imem_rsp_valid};
      w_base = r_count - w_pop;
      for (int i = 0; i < QB; i++) begin
         w_qd[i] = 8'h00;
         w_qe[i] = 1'b0;
         if (i + int'(w_pop) < QB) begin
            w_qd[i] = r_qd[i + int'(w_pop)];
            w_qe[i] = r_qe[i + int'(w_pop)];
         end
      end
      w_count      = w_base;
      w_skip       = r_skip;
      w_halted     = r_halted;
      w_discard    = r_discard;
      w_head_pc    = w_take ? r_head_pc + {60'h0, w_len} : r_head_pc;
      w_fetch_addr = w_acc ? r_fetch_addr + 64'd8 : r_fetch_addr;
      if (i_imem_rsp_valid && (r_discard != 3'd0)) begin
         w_discard = r_discard - 3'd1;
      end
      if (w_keep) begin
         for (int k = 0; k < 8; k++) begin
            if ((k >= int'(r_skip)) && (int'(w_base) + k - int'(r_skip) < QB)) begin
               w_qd[int'(w_base) + k - int'(r_skip)] = i_imem_rsp_data[8*k +: 8];
               w_qe[int'(w_base) + k - int'(r_skip)] = i_imem_rsp_err;
            end
         end
         w_count  = w_base + 6'd8 - {3'b000, r_skip};
         w_skip   = 3'd0;
         w_halted = r_halted | i_imem_rsp_err;
      end
      // Everything already requested, including a request accepted this cycle, is stale.
      if (i_redirect_valid) begin
         for (int i = 0; i < QB; i++) begin
            w_qd[i] = 8'h00;
            w_qe[i] = 1'b0;
         end
         w_count      = '0;
         w_discard    = w_out;
         w_head_pc    = i_redirect_pc;
         w_fetch_addr = {i_redirect_pc[63:3], 3'b000};
         w_skip       = i_redirect_pc[2:0];
         w_halted     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < QB; i++) begin
            r_qd[i] <= 8'h00;
            r_qe[i] <= 1'b0;
         end
         r_count      <= '0;
         r_out        <= '0;
         r_discard    <= '0;
         r_skip       <= RESET_PC[2:0];
         r_fetch_addr <= {RESET_PC[63:3], 3'b000};
         r_head_pc    <= RESET_PC;
         r_halted     <= 1'b0;
      end else begin
         for (int i = 0; i < QB; i++) begin
            r_qd[i] <= w_qd[i];
            r_qe[i] <= w_qe[i];
         end
         r_count      <= w_count;
         r_out        <= w_out;
         r_discard    <= w_discard;
         r_skip       <= w_skip;
         r_fetch_addr <= w_fetch_addr;
         r_head_pc    <= w_head_pc;
         r_halted     <= w_halted;
      end
   end

endmodule
